slider_movegen: RTL



---
 rtl/slider_movegen.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/slider_movegen.sv
// Sliding-piece successor generator. Loads a board from SDRAM, walks the enabled ray directions
// from the origin square, and writes one full successor board per pseudo-legal move.
module slider_movegen #(
  parameter int unsigned BOARD_DIM = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU-facing register slave
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [DATA_W-1:0] slave_readdata,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  // SDRAM-facing master
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam int unsigned NSQ  = BOARD_DIM * BOARD_DIM;
  localparam int unsigned IDXW = $clog2(NSQ);
  localparam int unsigned IW   = $clog2(BOARD_DIM);
  // Signed coordinate width: must hold -1 and BOARD_DIM after a step off the edge.
  localparam int unsigned CW   = IW + 2;
  localparam int unsigned SW   = IW + 1;

  localparam logic signed [CW-1:0] DimS     = CW'(BOARD_DIM);
  localparam logic signed [CW-1:0] One      = CW'(1);
  localparam logic signed [CW-1:0] MinusOne = {CW{1'b1}};

  typedef enum logic [3:0] {
    StIdle,
    StLoadReq,
    StLoadWait,
    StOrigin,
    StNextDir,
    StStep,
    StCheck,
    StEmit,
    StWrite,
    StDone
  } state_e;

  state_e state_q;

  logic [ADDR_W-1:0] src_q, dest_q, base_q;
  logic [IW-1:0]     x_q, y_q;
  logic [7:0]        dir_mask_q, dir_left_q;
  logic [DATA_W-1:0] range_q, max_boards_q, board_count_q;
  logic              overflow_q, busy_q, done_q;
  logic [7:0]        board_q [NSQ];
  logic [7:0]        piece_q;
  logic [IDXW-1:0]   j_q, org_idx_q, tgt_idx_q;
  logic signed [CW-1:0] tx_q, ty_q, dx_q, dy_q;
  logic [SW-1:0]     step_q;
  logic              ending_q;

  logic              parked, start;
  logic [IDXW-1:0]   org_idx, tgt_idx, nxt_j;
  logic [7:0]        tgt_val, nxt_val;
  logic [DATA_W-1:0] nxt_word, range_eff;
  logic              tgt_in, too_far, friendly;
  logic              nd_found;
  logic [2:0]        nd_idx;
  logic signed [CW-1:0] nd_dx, nd_dy;
  logic              unused_rdata;

  assign unused_rdata = ^master_readdata[DATA_W-1:8];

  // Slave never stalls outside reset.
  assign slave_waitrequest = rst;

  assign parked = (state_q == StIdle) || (state_q == StDone);
  assign start  = slave_write && (slave_address == 4'd0) && parked;

  // Register read mux, combinational from state.
  always_comb begin
    slave_readdata = '0;
    if (slave_address == 4'd0) begin
      slave_readdata = board_count_q;
    end else if (slave_address == 4'd8) begin
      slave_readdata = {{(DATA_W - 3){1'b0}}, overflow_q, busy_q, done_q};
    end
  end

  // Square geometry: origin/target indices, bounds, range and colour tests.
  always_comb begin
    org_idx   = IDXW'(y_q) * IDXW'(BOARD_DIM) + IDXW'(x_q);
    tgt_idx   = IDXW'(ty_q[IW-1:0]) * IDXW'(BOARD_DIM) + IDXW'(tx_q[IW-1:0]);
    tgt_val   = board_q[tgt_idx];
    tgt_in    = !tx_q[CW-1] && (tx_q < DimS) && !ty_q[CW-1] && (ty_q < DimS);
    range_eff = (range_q == '0) ? DATA_W'(BOARD_DIM - 1) : range_q;
    too_far   = DATA_W'(step_q) > range_eff;
    friendly  = (tgt_val != '0) && (tgt_val[7] == piece_q[7]);
  end

  // Lowest remaining enabled direction and its unit delta.
  always_comb begin
    nd_found = 1'b0;
    nd_idx   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (dir_left_q[k]) begin
        nd_found = 1'b1;
        nd_idx   = 3'(k);
      end
    end
    nd_dx = '0;
    nd_dy = '0;
    case (nd_idx)
      3'd0: nd_dy = One;
      3'd1: nd_dy = MinusOne;
      3'd2: nd_dx = MinusOne;
      3'd3: nd_dx = One;
      3'd4: begin nd_dx = One;      nd_dy = One;      end
      3'd5: begin nd_dx = MinusOne; nd_dy = One;      end
      3'd6: begin nd_dx = One;      nd_dy = MinusOne; end
      default: begin nd_dx = MinusOne; nd_dy = MinusOne; end
    endcase
  end

  // Next successor-board word: origin vacated, mover placed on target, rest copied.
  always_comb begin
    nxt_j = (state_q == StWrite) ? j_q + IDXW'(1) : '0;
    if (nxt_j == org_idx_q) begin
      nxt_val = '0;
    end else if (nxt_j == tgt_idx_q) begin
      nxt_val = piece_q;
    end else begin
      nxt_val = board_q[nxt_j];
    end
    nxt_word = {{(DATA_W - 8){nxt_val[7]}}, nxt_val};
  end

  // Control FSM with registered bus outputs and config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      src_q            <= '0;
      dest_q           <= '0;
      base_q           <= '0;
      x_q              <= '0;
      y_q              <= '0;
      dir_mask_q       <= '0;
      dir_left_q       <= '0;
      range_q          <= '0;
      max_boards_q     <= '0;
      board_count_q    <= '0;
      overflow_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      piece_q          <= '0;
      j_q              <= '0;
      org_idx_q        <= '0;
      tgt_idx_q        <= '0;
      tx_q             <= '0;
      ty_q             <= '0;
      dx_q             <= '0;
      dy_q             <= '0;
      step_q           <= '0;
      ending_q         <= 1'b0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
      for (int k = 0; k < NSQ; k++) board_q[k] <= '0;
    end else begin
      // Configuration only lands while no run is in flight.
      if (slave_write && parked) begin
        case (slave_address)
          4'd1: src_q        <= ADDR_W'(slave_writedata);
          4'd2: dest_q       <= ADDR_W'(slave_writedata);
          4'd3: x_q          <= slave_writedata[IW-1:0];
          4'd4: y_q          <= slave_writedata[IW-1:0];
          4'd5: dir_mask_q   <= slave_writedata[7:0];
          4'd6: range_q      <= slave_writedata;
          4'd7: max_boards_q <= slave_writedata;
          default: ;
        endcase
      end

      if (start) begin
        board_count_q  <= '0;
        overflow_q     <= 1'b0;
        done_q         <= 1'b0;
        busy_q         <= 1'b1;
        j_q            <= '0;
        master_read    <= 1'b1;
        master_address <= src_q;
        state_q        <= StLoadReq;
      end else begin
        case (state_q)
          StIdle: ;
          StLoadReq: begin
            if (!master_waitrequest) begin
              master_read <= 1'b0;
              state_q     <= StLoadWait;
            end
          end
          StLoadWait: begin
            if (master_readdatavalid) begin
              board_q[j_q] <= master_readdata[7:0];
              if (j_q == IDXW'(NSQ - 1)) begin
                state_q <= StOrigin;
              end else begin
                j_q            <= j_q + IDXW'(1);
                master_read    <= 1'b1;
                master_address <= src_q + ADDR_W'(j_q) + ADDR_W'(1);
                state_q        <= StLoadReq;
              end
            end
          end
          StOrigin: begin
            org_idx_q  <= org_idx;
            piece_q    <= board_q[org_idx];
            dir_left_q <= dir_mask_q;
            if (board_q[org_idx] == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StNextDir;
            end
          end
          StNextDir: begin
            if (nd_found) begin
              dir_left_q[nd_idx] <= 1'b0;
              dx_q    <= nd_dx;
              dy_q    <= nd_dy;
              tx_q    <= CW'(x_q);
              ty_q    <= CW'(y_q);
              step_q  <= '0;
              state_q <= StStep;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
          StStep: begin
            tx_q    <= tx_q + dx_q;
            ty_q    <= ty_q + dy_q;
            step_q  <= step_q + SW'(1);
            state_q <= StCheck;
          end
          StCheck: begin
            if (!tgt_in || too_far || friendly) begin
              state_q <= StNextDir;
            end else begin
              tgt_idx_q <= tgt_idx;
              // A capture is the last square of this ray.
              ending_q  <= (tgt_val != '0);
              state_q   <= StEmit;
            end
          end
          StEmit: begin
            if ((max_boards_q != '0) && (board_count_q == max_boards_q)) begin
              overflow_q <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              base_q           <= dest_q + ADDR_W'(board_count_q) * ADDR_W'(NSQ);
              master_address   <= dest_q + ADDR_W'(board_count_q) * ADDR_W'(NSQ);
              master_writedata <= nxt_word;
              master_write     <= 1'b1;
              j_q              <= '0;
              state_q          <= StWrite;
            end
          end
          StWrite: begin
            if (!master_waitrequest) begin
              if (j_q == IDXW'(NSQ - 1)) begin
                master_write  <= 1'b0;
                board_count_q <= board_count_q + DATA_W'(1);
                state_q       <= ending_q ? StNextDir : StStep;
              end else begin
                j_q              <= nxt_j;
                master_address   <= base_q + ADDR_W'(nxt_j);
                master_writedata <= nxt_word;
              end
            end
          end
          StDone: begin
            if (slave_read && (slave_address == 4'd0)) begin
              done_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
